// File: rtl/frame_serializer.sv
// ---------------------------------------------------------------------------
// frame_serializer
//
// Takes parallel payload words through a valid/ready handshake and sends each
// one as a framed serial stream on d_out. Frame layout on the line:
//    start(1), WIDTH payload bits LSB first, optional even-parity bit, stop(0)
// A one-entry hold register accepts the next word while the current frame is
// still shifting out, so frames can be sent back to back with no idle gap.
//
// Parameters
//    WIDTH      payload bits per frame (1..32)
//    PARITY_EN  1 appends the XOR of the payload bits, 0 omits it
//    CNT_W      width of frame_cnt
//
// Ports
//    clk         rising-edge clock for all state
//    rst         asynchronous, active-low reset
//    data_in     parallel payload word
//    valid_in    data_in is valid
//    ready_out   hold register is empty, a word can be accepted this cycle
//    d_out       registered serial output
//    busy        a frame is in flight or a word is held
//    frame_done  one-cycle pulse while the stop bit is on d_out
//    frame_cnt   count of completed frames, wraps at all-ones
// ---------------------------------------------------------------------------
module frame_serializer #(
   parameter int WIDTH     = 8,
   parameter int PARITY_EN = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             d_out,
   output logic             busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] frame_cnt
);

   // A 1-bit payload still needs a 1-bit counter, $clog2(1) would give 0.
   localparam int             BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] hold_reg;
   logic             hold_full;
   logic [WIDTH-1:0] shift_reg;
   logic [BCW-1:0]   bit_cnt;
   logic             parity_bit;
   logic             accept;
   logic             load_hold;

   // ready_out depends only on the registered hold flag, never on valid_in.
   assign ready_out = !hold_full;
   assign accept    = valid_in && !hold_full;
   // The FSM drains the hold register only from IDLE or at the end of STOP.
   assign load_hold = hold_full && ((state == IDLE) || (state == STOP));
   assign busy      = (state != IDLE) || hold_full;

   // Hold register. accept and load_hold can never coincide because one needs
   // the hold empty and the other needs it full.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_reg  <= '0;
         hold_full <= 1'b0;
      end else if (accept) begin
         hold_reg  <= data_in;
         hold_full <= 1'b1;
      end else if (load_hold) begin
         hold_full <= 1'b0;
      end
   end

   // Frame FSM. d_out and frame_done are registered from the current state,
   // so the line lags the state register by one cycle: a word accepted at
   // edge N moves the FSM to START at N+1 and the start bit appears at N+2.
   // Parity is taken from the hold word at load time so the shift register
   // is free to shift the payload out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         parity_bit <= 1'b0;
         d_out      <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               d_out <= 1'b0;
               if (hold_full) begin
                  shift_reg  <= hold_reg;
                  parity_bit <= ^hold_reg;
                  bit_cnt    <= '0;
                  state      <= START;
               end
            end
            START: begin
               d_out <= 1'b1;
               state <= DATA;
            end
            DATA: begin
               d_out     <= shift_reg[0];
               shift_reg <= shift_reg >> 1;
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  state   <= (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
               end
            end
            PARITY: begin
               d_out <= parity_bit;
               state <= STOP;
            end
            STOP: begin
               d_out      <= 1'b0;
               frame_done <= 1'b1;
               frame_cnt  <= frame_cnt + CNT_W'(1);
               // A held word goes straight to START so frames abut.
               if (hold_full) begin
                  shift_reg  <= hold_reg;
                  parity_bit <= ^hold_reg;
                  bit_cnt    <= '0;
                  state      <= START;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               d_out <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_frame_serializer
//
// Self-checking bench for frame_serializer. Three instances share clk/rst:
//    u_dut   WIDTH=8, PARITY_EN=1, CNT_W=16  (main scoreboard target)
//    u_wrap  CNT_W=2                         (frame counter wrap)
//    u_np    PARITY_EN=0                     (frame without parity)
// Accepted words for u_dut go into exp_q; a monitor deframes d_out and
// compares every received frame against the head of that queue.
// ---------------------------------------------------------------------------
module tb_frame_serializer;

   logic        clk;
   logic        rst;

   logic [7:0]  data_in;
   logic        valid_in;
   logic        ready_out;
   logic        d_out;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_cnt;

   logic [7:0]  data_w;
   logic        valid_w;
   logic        ready_w;
   logic        dout_w;
   logic        busy_w;
   logic        done_w;
   logic [1:0]  cnt_w;

   logic [7:0]  data_n;
   logic        valid_n;
   logic        ready_n;
   logic        dout_n;
   logic        busy_n;
   logic        done_n;
   logic [15:0] cnt_n;

   int          tests;
   int          fails;
   logic [7:0]  exp_q[$];

   int          mon_pos;
   logic [7:0]  mon_word;
   logic        mon_par;

   frame_serializer #(.WIDTH(8), .PARITY_EN(1), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .d_out(d_out), .busy(busy),
      .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   frame_serializer #(.WIDTH(8), .PARITY_EN(1), .CNT_W(2)) u_wrap (
      .clk(clk), .rst(rst), .data_in(data_w), .valid_in(valid_w),
      .ready_out(ready_w), .d_out(dout_w), .busy(busy_w),
      .frame_done(done_w), .frame_cnt(cnt_w)
   );

   frame_serializer #(.WIDTH(8), .PARITY_EN(0), .CNT_W(16)) u_np (
      .clk(clk), .rst(rst), .data_in(data_n), .valid_in(valid_n),
      .ready_out(ready_n), .d_out(dout_n), .busy(busy_n),
      .frame_done(done_n), .frame_cnt(cnt_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset across two edges and release it just after an edge, so the
   // following edge is the first one on which a word can be accepted.
   task automatic applyStimulus_reset();
      valid_in = 1'b0;
      valid_w  = 1'b0;
      valid_n  = 1'b0;
      rst      = 1'b0;
      exp_q.delete();
      step();
      step();
      rst = 1'b1;
   endtask

   // Scoreboard monitor: deframes u_dut's line on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         mon_pos = 0;
      end else if (mon_pos == 0) begin
         if (frame_done) checkOutput("done_outside_stop", int'(frame_done), 0);
         if (d_out) mon_pos = 1;
      end else if (mon_pos <= 8) begin
         if (frame_done) checkOutput("done_outside_stop", int'(frame_done), 0);
         mon_word = {d_out, mon_word[7:1]};
         mon_pos++;
      end else if (mon_pos == 9) begin
         if (frame_done) checkOutput("done_outside_stop", int'(frame_done), 0);
         mon_par = d_out;
         mon_pos++;
      end else begin
         checkOutput("sb_stop_bit", int'(d_out), 0);
         checkOutput("sb_frame_done", int'(frame_done), 1);
         if (exp_q.size() == 0) begin
            checkOutput("sb_unexpected_frame", int'(mon_word), -1);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checkOutput("sb_word", int'(mon_word), int'(e));
            checkOutput("sb_parity", int'(mon_par), int'(^e));
         end
         mon_pos = 0;
      end
   end

   initial begin
      int         a5_line[11];
      int         np_line[10];
      int         wrap_exp[5];
      logic [21:0] b2b_line;
      int         seen;
      int         accepts;
      int         drained;
      logic       acc;

      a5_line  = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
      np_line  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      wrap_exp = '{1, 2, 3, 0, 1};
      // Frame 0x01 then 0x03, first line bit in the MSB.
      b2b_line = 22'b11000000010_11100000000;

      tests    = 0;
      fails    = 0;
      mon_pos  = 0;
      mon_word = '0;
      mon_par  = 1'b0;
      rst      = 1'b1;
      data_in  = '0;
      valid_in = 1'b0;
      data_w   = '0;
      valid_w  = 1'b0;
      data_n   = '0;
      valid_n  = 1'b0;

      // Reset state, observed before any clock edge.
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_d_out", int'(d_out), 0);
      checkOutput("rst_ready", int'(ready_out), 1);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(frame_done), 0);
      checkOutput("rst_cnt", int'(frame_cnt), 0);
      step();
      step();
      rst = 1'b1;

      // Single word 0xA5, accepted on the first edge after reset release.
      data_in  = 8'hA5;
      valid_in = 1'b1;
      step();
      exp_q.push_back(8'hA5);
      valid_in = 1'b0;
      checkOutput("a5_ready_after_accept", int'(ready_out), 0);
      checkOutput("a5_busy_after_accept", int'(busy), 1);
      for (int k = 1; k <= 13; k++) begin
         step();
         if (k == 1) checkOutput("a5_latency_idle", int'(d_out), 0);
         if (k >= 2 && k <= 12) begin
            checkOutput($sformatf("a5_bit%0d", k - 2), int'(d_out), a5_line[k - 2]);
            checkOutput($sformatf("a5_done%0d", k - 2), int'(frame_done), (k == 12) ? 1 : 0);
         end
         if (k == 12) checkOutput("a5_cnt", int'(frame_cnt), 1);
         if (k == 13) checkOutput("a5_busy_end", int'(busy), 0);
      end

      // Reset in the middle of DATA bit 3, with a second word held.
      applyStimulus_reset();
      data_in  = 8'h0F;
      valid_in = 1'b1;
      step();
      exp_q.push_back(8'h0F);
      data_in = 8'h3C;
      step();
      step();
      exp_q.push_back(8'h3C);
      valid_in = 1'b0;
      for (int k = 3; k <= 6; k++) step();
      checkOutput("mid_bit3_before_rst", int'(d_out), 1);
      checkOutput("mid_ready_before_rst", int'(ready_out), 0);
      #2 rst = 1'b0;
      exp_q.delete();
      #1;
      checkOutput("mid_rst_d_out", int'(d_out), 0);
      checkOutput("mid_rst_ready", int'(ready_out), 1);
      checkOutput("mid_rst_busy", int'(busy), 0);
      checkOutput("mid_rst_done", int'(frame_done), 0);
      checkOutput("mid_rst_cnt", int'(frame_cnt), 0);
      step();
      step();
      rst  = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (d_out || frame_done) seen++;
      end
      checkOutput("mid_no_activity", seen, 0);
      checkOutput("mid_cnt_after", int'(frame_cnt), 0);

      // Back-to-back: 0x01, then 0x03 accepted while the first is in flight.
      applyStimulus_reset();
      data_in  = 8'h01;
      valid_in = 1'b1;
      step();
      exp_q.push_back(8'h01);
      valid_in = 1'b0;
      step();
      checkOutput("b2b_ready_edge1", int'(ready_out), 1);
      data_in  = 8'h03;
      valid_in = 1'b1;
      step();
      exp_q.push_back(8'h03);
      valid_in = 1'b0;
      for (int k = 2; k <= 23; k++) begin
         if (k > 2) step();
         checkOutput($sformatf("b2b_bit%0d", k - 2), int'(d_out), int'(b2b_line[23 - k]));
      end
      checkOutput("b2b_cnt", int'(frame_cnt), 2);

      // Backpressure: valid_in held high with 0xFF for 40 edges.
      applyStimulus_reset();
      data_in  = 8'hFF;
      valid_in = 1'b1;
      accepts  = 0;
      for (int e = 0; e < 40; e++) begin
         acc = ready_out;
         step();
         if (acc) begin
            accepts++;
            exp_q.push_back(8'hFF);
            checkOutput($sformatf("bp_ready_low%0d", accepts), int'(ready_out), 0);
         end
      end
      valid_in = 1'b0;
      checkOutput("bp_accepts", accepts, 5);
      drained = 0;
      for (int c = 0; c < 200 && drained == 0; c++) begin
         step();
         if (exp_q.size() == 0 && !busy) drained = 1;
      end
      checkOutput("bp_drained", drained, 1);
      step();
      checkOutput("bp_cnt", int'(frame_cnt), 5);

      // Counter wrap on the CNT_W=2 instance.
      applyStimulus_reset();
      for (int i = 0; i < 5; i++) begin
         data_w  = 8'h10 + 8'(i);
         valid_w = 1'b1;
         step();
         valid_w = 1'b0;
         for (int c = 0; c < 30 && !done_w; c++) step();
         checkOutput($sformatf("wrap_done_seen%0d", i), int'(done_w), 1);
         checkOutput($sformatf("wrap_cnt%0d", i), int'(cnt_w), wrap_exp[i]);
         step();
      end

      // No-parity instance: 0x80 gives a 10-cycle frame.
      applyStimulus_reset();
      data_n  = 8'h80;
      valid_n = 1'b1;
      step();
      valid_n = 1'b0;
      step();
      checkOutput("np_latency_idle", int'(dout_n), 0);
      for (int k = 2; k <= 11; k++) begin
         step();
         checkOutput($sformatf("np_bit%0d", k - 2), int'(dout_n), np_line[k - 2]);
         checkOutput($sformatf("np_done%0d", k - 2), int'(done_n), (k == 11) ? 1 : 0);
      end
      checkOutput("np_cnt", int'(cnt_n), 1);
      step();
      checkOutput("np_busy_end", int'(busy_n), 0);

      checkOutput("sb_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
